muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer attached beside the EX stage ALU of the five-stage pipeline.
- Accepts MULT/MULTU/DIV/DIVU issued from EX and owns the architectural HI/LO registers.
- Runs a 32-step shift-add / restoring-divide state machine.
- Raises a stall request while a later instruction needs HI/LO or the unit before it is free.

Parameters:
- WIDTH, 32, operand/result width; all counts below assume 32.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset
- start  in  1  EX holds a mul/div instruction this cycle
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  WIDTH  rs data (multiplicand / dividend)
- src_b  in  WIDTH  rt data (multiplier / divisor)
- hilo_read  in  1  EX holds MFHI/MFLO
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  WIDTH  rs data for MTHI/MTLO
- flush  in  1  cancel in-flight operation
- hi_out  out  WIDTH  HI register
- lo_out  out  WIDTH  LO register
- busy  out  1  operation in flight
- stall_req  out  1  hold IF/ID/EX this cycle
- done  out  1  one-cycle pulse, HI/LO just updated

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; HI=LO=0; busy=0; done=0; counter=0.
- States: IDLE, CALC, FIXUP.
- IDLE:
  - If start=1 at an edge: latch op, signedness, |src_a|, |src_b| and the sign bits; counter=0; go to CALC.
  - Signed ops take two's-complement magnitudes. Unsigned ops take the operands raw.
- CALC:
  - One iteration per cycle.
  - Multiply: shift-add over a 64-bit accumulator.
  - Divide: restoring step over a 32-bit remainder / quotient pair.
  - After the counter reaches 31, go to FIXUP. CALC lasts exactly 32 cycles.
- FIXUP:
  - Signed mul: negate the 64-bit product if sign_a^sign_b.
  - Signed div: negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
  - Write HI/LO at the FIXUP edge and return to IDLE.
  - Mul result: HI=product[63:32], LO=product[31:0]. Div result: HI=remainder, LO=quotient.
- Latency: start sampled at edge E0 → HI/LO valid after edge E33; done=1 during the cycle following E33.
- busy: high from the cycle after E0 through the FIXUP cycle inclusive.
- Divide by zero: runs full latency; result forced to HI=original src_a, LO=32'hFFFF_FFFF for both DIV and DIVU.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (falls out of magnitude arithmetic, no special case).
- stall_req: combinational, = busy & (start | hilo_read | mthi | mtlo).
  - start while busy is ignored. The stalled pipeline re-presents it.
  - hi_out/lo_out always show the committed registers.
- mthi/mtlo: take effect only when not busy.
  - If asserted in IDLE together with start, the move writes this edge and the new operation overwrites both HI and LO at completion.
- flush: at any edge forces IDLE; busy=0 next cycle; HI/LO unchanged; no done pulse.
  - flush in IDLE with start=1 drops the start.
  - flush in the FIXUP cycle suppresses the write.
- rst mid-operation: identical to reset values; any in-flight result is lost.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU bypass CALC. A single-cycle WIDTH×WIDTH product (signed or unsigned per op) is latched at E0, then FIXUP.
  - HI/LO are valid after E1; done is high in the cycle after E1; busy is high for one cycle.
  - Divides are unchanged.
- Not defined: all ops use the 32-cycle iterative path; no hardware multiplier is inferred.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state encoding ST_IDLE, ST_CALC, ST_FIXUP;
  - WIDTH default;
  - DIV0_LO constant 32'hFFFF_FFFF.
- One natural sub-module, muldiv_iter_step: purely combinational single iteration.
  - Mode bit selects add-shift or subtract-compare-shift.
  - Inputs: accumulator/remainder, operand. Outputs: next state.
  - The FSM, counter, sign fixup and HI/LO live in muldiv_ctrl.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF → after 34 cycles HI=0xFFFFFFFE, LO=0x00000001, one done pulse, busy high 33 cycles.
- MULT 0xFFFFFFFD(−3)×7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; with MULDIV_FAST_MUL_EN the same values are valid after E1.
- DIV 0xFFFFFFF9(−7)/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0; DIVU 100/0 → HI=100, LO=0xFFFFFFFF.
- DIVU 1000/7 with hilo_read asserted on cycles 1–33 → stall_req high every one of those cycles, low after done; a second start during busy is ignored until IDLE.
- mthi 0x1234 in IDLE → hi_out=0x1234 next cycle; MULTU 3×5 started, flush at cycle 10 → busy=0 next cycle, HI=0x1234 retained, no done.
- rst asserted at cycle 20 of a DIVU → HI=LO=0, busy=0, done=0 next cycle; new MULTU 2×3 then gives LO=6.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CALC  = 2'b01,
    ST_FIXUP = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step
// over a double-width accumulator ({hi, lo} or {remainder, quotient}).
module muldiv_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic                 mode_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;

  always_comb begin
    mul_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
    // Remainder shifted left with the next dividend bit; one extra bit catches borrow.
    rem_sh  = acc_in[2*WIDTH-1:WIDTH-1];
    trial   = {1'b0, rem_sh} - {2'b00, operand};
    if (mode_div) begin
      if (trial[WIDTH+1]) begin
        acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end else begin
        acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_out = {mul_sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer owning HI/LO. Optional MULDIV_FAST_MUL_EN replaces the
// 32-cycle multiply with a single-cycle product; divides always iterate.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hilo_read,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             stall_req,
  output logic             done
);

  localparam int DW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             div0_q, div0_d;
  logic             done_q, done_d;

  logic             op_signed, in_sign_a, in_sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [DW-1:0]    step_acc, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Sign flags are pre-masked by signedness, so fixup never needs the op again.
  assign op_signed = ~op[0];
  assign in_sign_a = op_signed & src_a[WIDTH-1];
  assign in_sign_b = op_signed & src_b[WIDTH-1];
  assign mag_a     = in_sign_a ? -src_a : src_a;
  assign mag_b     = in_sign_b ? -src_b : src_b;

  muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
    .mode_div (is_div_q),
    .acc_in   (acc_q),
    .operand  (opnd_q),
    .acc_out  (step_acc)
  );

  assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  assign quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = sign_a_q ? -acc_q[DW-1:WIDTH] : acc_q[DW-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
  logic [DW-1:0] fast_prod;
  assign fast_prod = DW'(mag_a) * DW'(mag_b);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    div0_d   = div0_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start) begin
          is_div_d = op[1];
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          div0_d   = (src_b == '0);
          cnt_d    = '0;
          if (op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, mag_a};
            opnd_d = mag_b;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, mag_b};
            opnd_d = mag_a;
          end
          state_d = ST_CALC;
`ifdef MULDIV_FAST_MUL_EN
          if (!op[1]) begin
            acc_d   = fast_prod;
            state_d = ST_FIXUP;
          end
`endif
        end
      end
      ST_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIXUP;
      end
      ST_FIXUP: begin
        if (is_div_q) begin
          // A zero divisor leaves |a| in the remainder, which fixes up back to src_a.
          hi_d = rem_fix;
          lo_d = div0_q ? DIV0_LO : quo_fix;
        end else begin
          hi_d = prod_fix[DW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      if (state_q == ST_FIXUP) begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign stall_req = busy & (start | hilo_read | mthi | mtlo);
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign done      = done_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl; expected HI/LO are queued at issue and
// checked by a monitor on each done pulse. Honours MULDIV_FAST_MUL_EN latency.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic        hilo_read, mthi, mtlo, flush;
  logic [31:0] hi_out, lo_out;
  logic        busy, stall_req, done;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests    = 0;
  int   fails    = 0;
  int   done_cnt = 0;
  int   n_pushed = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int          MUL_BUSY = 1;
  localparam logic [1:0]  FLUSH_OP = 2'b11;
`else
  localparam int          MUL_BUSY = 33;
  localparam logic [1:0]  FLUSH_OP = 2'b01;
`endif

  muldiv_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .hilo_read (hilo_read),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .flush     (flush),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  task automatic sb_push(input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    sb_q.push_back(e);
    n_pushed++;
  endtask

  // Called at a negedge; returns at the negedge after the unit goes idle.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int exp_busy);
    int n;
    sb_push(eh, el);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 32'(n), 32'(exp_busy));
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 with hi=%h lo=%h, expected no done", hi_out, lo_out);
      end else begin
        mon_e = sb_q.pop_front();
        check("result_hi", hi_out, mon_e.hi);
        check("result_lo", lo_out, mon_e.lo);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ns;
    logic [31:0] hi_keep, lo_keep;
    int done_keep;

    rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    wdata = '0; hilo_read = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_hi", hi_out, 32'h0);
    check("reset_lo", lo_out, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    @(negedge clk);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_BUSY);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_BUSY);
    run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_BUSY);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("div_negb",  2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);
    run_op("divu_zero", 2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 33);
    run_op("div_zero",  2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 33);

    // hilo_read held while busy; a second start is presented mid-operation.
    sb_push(32'd6, 32'd142);
    sb_push(32'd1, 32'd7);
    start = 1'b1; op = 2'b11; src_a = 32'd1000; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0; hilo_read = 1'b1;
    n = 0; ns = 0;
    while (busy && n < 100) begin
      n++;
      if (stall_req) ns++;
      if (n == 5) begin
        start = 1'b1; src_a = 32'd50;
      end
      @(negedge clk);
    end
    check("stall_busy_cycles", 32'(n), 32'd33);
    check("stall_cycles", 32'(ns), 32'd33);
    check("stall_after_done", 32'(stall_req), 32'h0);
    hilo_read = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("second_start_busy", 32'(n), 32'd33);

    // mtlo alongside start writes now; the multiply overwrites LO later.
    sb_push(32'd0, 32'd6);
    start = 1'b1; op = 2'b01; src_a = 32'd2; src_b = 32'd3; mtlo = 1'b1; wdata = 32'h0000_AAAA;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    check("mtlo_with_start", lo_out, 32'h0000_AAAA);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("mtlo_op_busy", 32'(n), 32'(MUL_BUSY));

    // mthi in idle, then flush an operation at cycle 10.
    mthi = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_idle", hi_out, 32'h0000_1234);
    lo_keep = lo_out;
    done_keep = done_cnt;
    start = 1'b1; op = FLUSH_OP; src_a = 32'd3; src_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_pre_busy", 32'(busy), 32'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'h0);
    check("flush_hi", hi_out, 32'h0000_1234);
    check("flush_lo", lo_out, lo_keep);
    repeat (40) @(negedge clk);
    check("flush_no_done", 32'(done_cnt), 32'(done_keep));

    // flush landing in the fixup cycle must suppress the HI/LO write.
    hi_keep = hi_out; lo_keep = lo_out;
    start = 1'b1; op = 2'b11; src_a = 32'd9; src_b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    check("fixup_flush_pre_busy", 32'(busy), 32'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fixup_flush_busy", 32'(busy), 32'h0);
    check("fixup_flush_hi", hi_out, hi_keep);
    check("fixup_flush_lo", lo_out, lo_keep);
    repeat (3) @(negedge clk);

    // reset mid-divide.
    start = 1'b1; op = 2'b11; src_a = 32'd1000; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("rst_pre_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_hi", hi_out, 32'h0);
    check("rst_mid_lo", lo_out, 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_done", 32'(done), 32'h0);
    run_op("multu_after_rst", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, MUL_BUSY);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'(n_pushed));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
